// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the
// sequential Booth multiplier.
package mult_pkg;
  localparam int WIDTH    = 32;
  localparam int ACC_W    = 33;
  localparam int PROD_W   = 66;
  localparam int CNT_LAST = 31;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub the
// multiplicand into the accumulator, then ASR by 1.
module booth_step
  import mult_pkg::*;
(
  input  logic [PROD_W-1:0] i_prod,
  input  logic [ACC_W-1:0]  i_mcand,
  output logic [PROD_W-1:0] o_prod
);

  logic [ACC_W-1:0]  w_acc;
  logic [ACC_W-1:0]  w_sum;
  logic [PROD_W-1:0] w_cat;

  always_comb begin
    w_acc = i_prod[PROD_W-1:ACC_W];
    w_sum = w_acc;
    unique case (i_prod[1:0])
      2'b01:   w_sum = w_acc + i_mcand;
      2'b10:   w_sum = w_acc - i_mcand;
      default: w_sum = w_acc;
    endcase
    w_cat  = {w_sum, i_prod[ACC_W-1:0]};
    o_prod = {w_cat[PROD_W-1], w_cat[PROD_W-1:1]};
  end

endmodule

// File: rtl/mult_sequencer.sv
// Sequential radix-2 Booth multiplier: 32 steps,
// low word result, overflow flag, ready pulse.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t            r_state, w_state_nxt;
  logic [PROD_W-1:0] r_prod, w_prod_nxt, w_step;
  logic [ACC_W-1:0]  r_mcand, w_mcand_nxt;
  logic [5:0]        r_count, w_count_nxt;
  logic [WIDTH-1:0]  r_result, w_result_nxt;
  logic              r_exc, w_exc_nxt;
  logic              r_rdy, w_rdy_nxt;
  logic              r_busy, w_busy_nxt;

  booth_step u_step (
    .i_prod  (r_prod),
    .i_mcand (r_mcand),
    .o_prod  (w_step)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_prod_nxt   = r_prod;
    w_mcand_nxt  = r_mcand;
    w_count_nxt  = r_count;
    w_result_nxt = r_result;
    w_exc_nxt    = r_exc;
    w_rdy_nxt    = 1'b0;
    if (ctrl_MULT) begin
      // a start always wins, aborting any run
      w_prod_nxt  = {{ACC_W{1'b0}}, data_operandB, 1'b0};
      w_mcand_nxt = {data_operandA[WIDTH-1], data_operandA};
      w_count_nxt = 6'd0;
      w_state_nxt = RUN;
    end else begin
      unique case (r_state)
        RUN: begin
          w_prod_nxt  = w_step;
          w_count_nxt = r_count + 6'd1;
          if (r_count == 6'(CNT_LAST)) begin
            w_state_nxt  = DONE;
            w_result_nxt = w_step[WIDTH:1];
            w_exc_nxt    = !((&w_step[PROD_W-1:WIDTH]) ||
                             (~|w_step[PROD_W-1:WIDTH]));
            w_rdy_nxt    = 1'b1;
          end
        end
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
    w_busy_nxt = (w_state_nxt == RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prod   <= w_prod_nxt;
      r_mcand  <= w_mcand_nxt;
      r_count  <= w_count_nxt;
      r_result <= w_result_nxt;
      r_exc    <= w_exc_nxt;
      r_rdy    <= w_rdy_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule
